// File: rtl/upower_fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues 1-cycle-latency reads, buffers replies for decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module upower_fetch_controller #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PROG_WORDS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  busy,
`ifdef FETCH_PERF_EN
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall,
`endif
  output logic                  done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] END_PC  = ADDR_WIDTH'(PROG_WORDS);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = 1;
  localparam logic [PTR_W-1:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  inflight;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [31:0]           fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];

  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           pc_at_end;
  logic [CNT_W:0] slots_used;
  logic [CNT_W:0] slot_limit;

  assign fifo_empty = (count == '0);
  assign pc_at_end  = (pc >= END_PC);
  assign pop        = instr_valid && instr_ready;
  assign push       = (state == S_RUN) && inflight && !redirect_valid;

  // A pop this cycle frees a slot before the reply lands, which keeps 1 instr/cycle with depth 2.
  assign slots_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign slot_limit = (CNT_W+1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop};

  assign imem_req    = (state == S_RUN) && !redirect_valid && !pc_at_end && (slots_used < slot_limit);
  assign imem_addr   = pc;
  assign instr_valid = !fifo_empty && !redirect_valid;
  assign instr       = fifo_empty ? '0 : fifo_instr[rd_ptr];
  assign instr_pc    = fifo_empty ? '0 : fifo_pc[rd_ptr];
  assign busy        = (state == S_RUN) || (state == S_FLUSH);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc     <= pc + PC_ONE;
        req_pc <= pc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;

      // Later assignments below (clear, PC load) override the datapath updates above.
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state  <= S_RUN;
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
          end
        end
        S_RUN: begin
          if (redirect_valid) begin
            pc     <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (redirect_pc >= END_PC) state <= S_DONE;
            else if (inflight)         state <= S_FLUSH;
          end else if (pc_at_end && !inflight && fifo_empty) begin
            state <= S_DONE;
          end
        end
        S_FLUSH: begin
          if (redirect_valid) begin
            pc     <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
          end
          state <= (redirect_valid && (redirect_pc >= END_PC)) ? S_DONE : S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= req_pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_cycle;
  logic start_accept;

  assign stall_cycle  = (state == S_RUN) && instr_valid && !instr_ready;
  assign start_accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else if (start_accept) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && (perf_fetched != '1))      perf_fetched <= perf_fetched + 32'd1;
      if (stall_cycle && (perf_stall != '1)) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_upower_fetch_controller.sv
// Bench for upower_fetch_controller: directed scenarios plus random traffic vs. a queue-based model.
module tb_upower_fetch_controller;
  localparam int          AW    = 32;
  localparam int          DEPTH = 2;
  localparam int          PROG  = 3;
  localparam logic [31:0] RPC   = 32'd0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, instr_valid, busy, done;
  logic [31:0] imem_addr, instr, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  upower_fetch_controller #(
    .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC), .PROG_WORDS(PROG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Model: buffered words in a queue, one outstanding read, and the controller's current mode.
  typedef struct packed {logic [31:0] word; logic [31:0] pc;} entry_t;
  typedef enum {M_IDLE, M_RUN, M_FLUSH, M_DONE} mode_t;

  entry_t      q[$];
  mode_t       mode;
  logic [31:0] m_pc, m_pend_pc, m_fetched, m_stall;
  bit          m_pend;
  logic        exp_req, exp_valid;
  logic [31:0] exp_addr, exp_instr, exp_ipc;
  logic        last_req;
  logic [31:0] last_addr;
  int          n_checks = 0;
  int          n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h7C221A14;
      32'd1:   return 32'h38210001;
      32'd2:   return 32'h48000008;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mode      = M_IDLE;
    q.delete();
    m_pc      = RPC;
    m_pend    = 0;
    m_pend_pc = '0;
    m_fetched = '0;
    m_stall   = '0;
  endtask

  task automatic model_eval();
    int  used;
    bit  pop;
    exp_valid = (q.size() != 0) && !redirect_valid;
    exp_instr = (q.size() != 0) ? q[0].word : 32'd0;
    exp_ipc   = (q.size() != 0) ? q[0].pc : 32'd0;
    pop       = exp_valid && instr_ready;
    used      = q.size() + int'(m_pend) - int'(pop);
    exp_req   = (mode == M_RUN) && !redirect_valid && (m_pc < PROG) && (used < DEPTH);
    exp_addr  = m_pc;
  endtask

  task automatic model_advance();
    bit pop;
    int qsz;
    pop = exp_valid && instr_ready;
    qsz = q.size();
    if (mode == M_RUN && exp_valid && !instr_ready && m_stall != '1) m_stall++;
    case (mode)
      M_IDLE, M_DONE: begin
        if (start) begin
          mode = M_RUN; m_pc = RPC; q.delete(); m_fetched = '0; m_stall = '0;
        end
        m_pend = 0;
      end
      M_RUN: begin
        if (redirect_valid) begin
          q.delete();
          m_pc = redirect_pc;
          mode = (redirect_pc >= PROG) ? M_DONE : (m_pend ? M_FLUSH : M_RUN);
          m_pend = 0;
        end else begin
          if (m_pc >= PROG && !m_pend && qsz == 0) mode = M_DONE;
          if (pop) void'(q.pop_front());
          if (m_pend) begin
            q.push_back({mem_word(m_pend_pc), m_pend_pc});
            if (m_fetched != '1) m_fetched++;
          end
          if (exp_req) begin
            m_pend = 1; m_pend_pc = m_pc; m_pc = m_pc + 32'd1;
          end else begin
            m_pend = 0;
          end
        end
      end
      M_FLUSH: begin
        if (redirect_valid) begin
          m_pc = redirect_pc;
          mode = (redirect_pc >= PROG) ? M_DONE : M_RUN;
        end else begin
          mode = M_RUN;
        end
        m_pend = 0;
      end
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("imem_addr", imem_addr, exp_addr);
    chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
    chk("instr", instr, exp_instr);
    chk("instr_pc", instr_pc, exp_ipc);
    chk("busy", 32'(busy), 32'(mode == M_RUN || mode == M_FLUSH));
    chk("done", 32'(done), 32'(mode == M_DONE));
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall, m_stall);
`endif
  endtask

  // One clock: drive at negedge, check #1 later, advance the model at posedge, answer the read.
  task automatic cycle(input bit st, input bit rdy, input bit rv, input logic [31:0] rpc);
    start = st; instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    model_eval();
    check_outputs();
    if (exp_valid && instr_ready) $display("xfer pc=%0d instr=%h", exp_ipc, exp_instr);
    if (rv) $display("redirect to pc=%0d", rpc);
    last_req  = imem_req;
    last_addr = imem_addr;
    @(posedge clk);
    model_advance();
    @(negedge clk);
    imem_rdata = last_req ? mem_word(last_addr) : $urandom();
  endtask

  initial begin
    model_reset();
    #1;
    model_eval();
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Straight run with decode always ready: three back-to-back transfers, then done.
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);
    chk("done_after_run", 32'(done), 32'd1);

    // Decode stalled: only two reads go out; head holds; release drains in order.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
`ifdef FETCH_PERF_EN
    chk("perf_stall_held", perf_stall, 32'd4);
    chk("perf_fetched_held", perf_fetched, 32'd2);
`endif
    chk("held_instr", instr, 32'h7C221A14);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_end", perf_fetched, 32'd3);
`endif

    // Redirect to 1 while pc 0 is presented and a read is in flight.
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32'd1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);

    // Redirect beyond the program end.
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32'd5);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    chk("done_after_far_redirect", 32'(done), 32'd1);

    // Asynchronous reset with two entries buffered.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    chk("buffered_before_reset", 32'(instr_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    model_eval();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, 32'($urandom_range(0, 5)));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
